// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter shared by fetch and execute stages
//
// Purpose:
//   Grants one of the fetch (if_*) or execute (dm_*) requests per cycle, drives the
//   memory port combinationally in the grant cycle and routes returned read data to
//   the issuing stage through a MEM_LAT-deep {valid, owner} tag pipeline.
//   Optional fairness is built when the macro ARB_FAIR_EN is defined.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   if_req/if_addr                fetch read request, held until if_gnt
//   if_gnt/if_rvalid/if_rdata     fetch grant and read return
//   dm_req/dm_we/dm_addr/dm_wdata execute load/store request, held until dm_gnt
//   dm_gnt/dm_rvalid/dm_rdata     execute grant and load return
//   mem_read_en/mem_write_en      memory strobes
//   mem_addr/mem_wdata/mem_rdata  memory address, write data, read data
//   busy                          any read in flight
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  generate
    if (MEM_LAT < 1) begin : g_bad_lat
      $error("mem_port_arbiter: MEM_LAT must be >= 1");
    end
  endgenerate

  // Tag pipeline: stage 0 is loaded in the grant cycle, stage MEM_LAT-1 lines up
  // with mem_rdata. Owner bit: 1 = execute, 0 = fetch.
  logic [MEM_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [MEM_LAT-1:0] tag_own_q, tag_own_d;

  logic force_if;
  logic dm_win;
  logic if_win;
  logic rd_push;
  logic ret_vld;
  logic ret_own;

`ifdef ARB_FAIR_EN
  // Extra bit keeps the width non-zero and lets the counter hold STARVE_MAX itself.
  localparam int CNT_W = $clog2(STARVE_MAX + 2);

  logic [CNT_W-1:0] starve_q, starve_d;

  assign force_if = (starve_q >= CNT_W'(STARVE_MAX));

  always_comb begin
    starve_d = starve_q;
    if (!if_req || if_win) begin
      starve_d = '0;
    end else if (starve_q < CNT_W'(STARVE_MAX)) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  // Execute wins by default: it holds the older instruction, so letting fetch
  // block it could deadlock the pipeline. Grants are forced low during reset.
  assign dm_win  = rst_n & dm_req & ~(force_if & if_req);
  assign if_win  = rst_n & if_req & ~dm_win;
  assign rd_push = if_win | (dm_win & ~dm_we);

  assign if_gnt       = if_win;
  assign dm_gnt       = dm_win;
  assign mem_read_en  = rd_push;
  assign mem_write_en = dm_win & dm_we;
  assign mem_addr     = dm_win ? dm_addr : if_addr;
  assign mem_wdata    = dm_wdata;

  always_comb begin
    tag_vld_d    = tag_vld_q;
    tag_own_d    = tag_own_q;
    tag_vld_d[0] = rd_push;
    tag_own_d[0] = dm_win;
    for (int i = 1; i < MEM_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_own_d[i] = tag_own_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q <= '0;
      tag_own_q <= '0;
    end else begin
      tag_vld_q <= tag_vld_d;
      tag_own_q <= tag_own_d;
    end
  end

  assign ret_vld   = tag_vld_q[MEM_LAT-1];
  assign ret_own   = tag_own_q[MEM_LAT-1];
  assign if_rvalid = ret_vld & ~ret_own;
  assign dm_rvalid = ret_vld & ret_own;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign dm_rdata  = dm_rvalid ? mem_rdata : '0;
  assign busy      = |tag_vld_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter at MEM_LAT 1 and 3
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;

  logic [1:0]  if_gnt_w, if_rvalid_w, dm_gnt_w, dm_rvalid_w;
  logic [1:0]  mem_read_en_w, mem_write_en_w, busy_w;
  logic [31:0] if_rdata_w [2];
  logic [31:0] dm_rdata_w [2];
  logic [31:0] mem_addr_w [2];
  logic [31:0] mem_wdata_w [2];
  logic [31:0] mem_rdata_w [2];

  int lat [2] = '{1, 3};

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_w[0]),
    .if_rvalid(if_rvalid_w[0]), .if_rdata(if_rdata_w[0]),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt_w[0]), .dm_rvalid(dm_rvalid_w[0]), .dm_rdata(dm_rdata_w[0]),
    .mem_read_en(mem_read_en_w[0]), .mem_write_en(mem_write_en_w[0]),
    .mem_addr(mem_addr_w[0]), .mem_wdata(mem_wdata_w[0]), .mem_rdata(mem_rdata_w[0]),
    .busy(busy_w[0])
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_w[1]),
    .if_rvalid(if_rvalid_w[1]), .if_rdata(if_rdata_w[1]),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt_w[1]), .dm_rvalid(dm_rvalid_w[1]), .dm_rdata(dm_rdata_w[1]),
    .mem_read_en(mem_read_en_w[1]), .mem_write_en(mem_write_en_w[1]),
    .mem_addr(mem_addr_w[1]), .mem_wdata(mem_wdata_w[1]), .mem_rdata(mem_rdata_w[1]),
    .busy(busy_w[1])
  );

  // Memory models, one per DUT, with 1- and 3-cycle read latency.
  logic [31:0] mem0 [logic [31:0]];
  logic [31:0] mem1 [logic [31:0]];
  logic [31:0] pipe1 = '0;
  logic [31:0] pipe3 [3] = '{32'h0, 32'h0, 32'h0};
  assign mem_rdata_w[0] = pipe1;
  assign mem_rdata_w[1] = pipe3[2];

  initial begin
    mem0[32'h10] = 32'hA5A5A5A5; mem1[32'h10] = 32'hA5A5A5A5;
    mem0[32'h14] = 32'h14141414; mem1[32'h14] = 32'h14141414;
    mem0[32'h18] = 32'h18181818; mem1[32'h18] = 32'h18181818;
    mem0[32'h40] = 32'h40404040; mem1[32'h40] = 32'h40404040;
    mem0[32'h44] = 32'h44444444; mem1[32'h44] = 32'h44444444;
    forever begin
      @(posedge clk);
      pipe1 = (mem_read_en_w[0] && mem0.exists(mem_addr_w[0])) ? mem0[mem_addr_w[0]] : 32'h0;
      pipe3[2] = pipe3[1];
      pipe3[1] = pipe3[0];
      pipe3[0] = (mem_read_en_w[1] && mem1.exists(mem_addr_w[1])) ? mem1[mem_addr_w[1]] : 32'h0;
      if (mem_write_en_w[0]) mem0[mem_addr_w[0]] = mem_wdata_w[0];
      if (mem_write_en_w[1]) mem1[mem_addr_w[1]] = mem_wdata_w[1];
    end
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (MEM_LAT=%0d) cyc=%0d: got %0h expected %0h", name, lat[d], cyc, act, exp);
    end
  endtask

  typedef struct {
    logic        owner;
    logic [31:0] data;
    int          due;
  } sb_t;

  sb_t sbq0 [$];
  sb_t sbq1 [$];
  int  rd_cycs [$];

  function automatic logic busy_exp(input int l, input int k);
    foreach (rd_cycs[i]) begin
      if (rd_cycs[i] < k && k <= rd_cycs[i] + l) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Monitor: pops the scoreboard whenever a DUT returns read data.
  task automatic mon(input int d);
    sb_t  it;
    logic any;
    int   qs;
    any = if_rvalid_w[d] | dm_rvalid_w[d];
    qs  = (d == 0) ? sbq0.size() : sbq1.size();
    if (any) begin
      chk("rvalid_onehot", d, 64'(if_rvalid_w[d] & dm_rvalid_w[d]), 64'd0);
      if (qs == 0) begin
        chk("spurious_rvalid", d, 64'(any), 64'd0);
      end else begin
        if (d == 0) it = sbq0.pop_front(); else it = sbq1.pop_front();
        chk("ret_owner", d, 64'(dm_rvalid_w[d]), 64'(it.owner));
        chk("ret_data", d, 64'(dm_rvalid_w[d] ? dm_rdata_w[d] : if_rdata_w[d]), 64'(it.data));
        chk("ret_other_rdata", d, 64'(dm_rvalid_w[d] ? if_rdata_w[d] : dm_rdata_w[d]), 64'd0);
        chk("ret_cycle", d, 64'(cyc), 64'(it.due));
      end
    end else if (qs != 0) begin
      if (d == 0) it = sbq0[0]; else it = sbq1[0];
      if (it.due <= cyc) begin
        chk("missing_rvalid", d, 64'(any), 64'd1);
        if (d == 0) void'(sbq0.pop_front()); else void'(sbq1.pop_front());
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    #2;
    mon(0);
    mon(1);
  end

  // Requesters must hold their request fields stable until granted.
  logic        hold_if = 1'b0, hold_dm = 1'b0;
  logic [31:0] prev_ia = '0, prev_da = '0, prev_dd = '0;
  logic        prev_dw = 1'b0;
  initial forever begin
    @(posedge clk);
    if (rst_n && hold_if && if_req && if_addr != prev_ia) begin
      n_err++;
      $display("FAIL if_hold: if_addr %0h changed from %0h before grant", if_addr, prev_ia);
    end
    if (rst_n && hold_dm && dm_req && {dm_we, dm_addr, dm_wdata} != {prev_dw, prev_da, prev_dd}) begin
      n_err++;
      $display("FAIL dm_hold: dm request fields changed before grant");
    end
    hold_if = rst_n && if_req && !if_gnt_w[0];
    hold_dm = rst_n && dm_req && !dm_gnt_w[0];
    prev_ia = if_addr; prev_da = dm_addr; prev_dd = dm_wdata; prev_dw = dm_we;
  end

  typedef struct {
    bit          rst;
    bit          ir;
    logic [31:0] ia;
    bit          dr;
    bit          dw;
    logic [31:0] da;
    logic [31:0] dd;
    bit          eig;
    bit          edg;
    logic [31:0] ed;
  } vec_t;

  vec_t vecs [$];

  function automatic void add(input bit rst, input bit ir, input logic [31:0] ia,
                              input bit dr, input bit dw, input logic [31:0] da,
                              input logic [31:0] dd, input bit eig, input bit edg,
                              input logic [31:0] ed);
    vec_t v;
    v.rst = rst; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw;
    v.da = da; v.dd = dd; v.eig = eig; v.edg = edg; v.ed = ed;
    vecs.push_back(v);
  endfunction

  function automatic void idle(input int n);
    for (int i = 0; i < n; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic apply(input vec_t v);
    logic exp_rd, exp_wr;
    sb_t  it;
    @(negedge clk);
    rst_n = !v.rst;
    if_req = v.ir; if_addr = v.ia;
    dm_req = v.dr; dm_we = v.dw; dm_addr = v.da; dm_wdata = v.dd;
    if (v.rst) begin
      sbq0.delete(); sbq1.delete(); rd_cycs.delete();
    end
    #1;
    exp_rd = v.eig | (v.edg & !v.dw);
    exp_wr = v.edg & v.dw;
    for (int d = 0; d < 2; d++) begin
      chk("if_gnt", d, 64'(if_gnt_w[d]), 64'(v.eig));
      chk("dm_gnt", d, 64'(dm_gnt_w[d]), 64'(v.edg));
      chk("mem_read_en", d, 64'(mem_read_en_w[d]), 64'(exp_rd));
      chk("mem_write_en", d, 64'(mem_write_en_w[d]), 64'(exp_wr));
      if (exp_rd || exp_wr) chk("mem_addr", d, 64'(mem_addr_w[d]), 64'(v.edg ? v.da : v.ia));
      if (exp_wr) chk("mem_wdata", d, 64'(mem_wdata_w[d]), 64'(v.dd));
      chk("busy", d, 64'(busy_w[d]), 64'(busy_exp(lat[d], cyc)));
      if (v.rst) begin
        chk("rst_rvalid", d, 64'({if_rvalid_w[d], dm_rvalid_w[d]}), 64'd0);
        chk("rst_rdata", d, {if_rdata_w[d], dm_rdata_w[d]}, 64'd0);
      end
    end
    if (exp_rd) begin
      it.owner = v.edg; it.data = v.ed;
      it.due = cyc + 1; sbq0.push_back(it);
      it.due = cyc + 3; sbq1.push_back(it);
      rd_cycs.push_back(cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state with both requests raised: everything must stay quiet.
    add(1, 1, 32'h10, 1, 0, 32'h40, 0, 0, 0, 0);
    idle(2);
    // Single fetch.
    add(0, 1, 32'h10, 0, 0, 0, 0, 1, 0, 32'hA5A5A5A5);
    idle(3);
    // Contention: execute first, fetch next cycle.
    add(0, 1, 32'h14, 1, 0, 32'h40, 0, 0, 1, 32'h40404040);
    add(0, 1, 32'h14, 0, 0, 0, 0, 1, 0, 32'h14141414);
    idle(4);
    // Store then load to the same address.
    add(0, 0, 0, 1, 1, 32'h20, 32'hDEADBEEF, 0, 1, 0);
    add(0, 0, 0, 1, 0, 32'h20, 0, 0, 1, 32'hDEADBEEF);
    idle(4);
    // Both held for 10 cycles.
    for (int c = 1; c <= 10; c++) begin
`ifdef ARB_FAIR_EN
      if (c == 5 || c == 10) add(0, 1, 32'h18, 1, 0, 32'h44, 0, 1, 0, 32'h18181818);
      else                   add(0, 1, 32'h18, 1, 0, 32'h44, 0, 0, 1, 32'h44444444);
`else
      add(0, 1, 32'h18, 1, 0, 32'h44, 0, 0, 1, 32'h44444444);
`endif
    end
    add(0, 1, 32'h18, 0, 0, 0, 0, 1, 0, 32'h18181818);
    idle(4);
    // Alternating fetch/execute loads, back to back.
    add(0, 1, 32'h10, 0, 0, 0, 0, 1, 0, 32'hA5A5A5A5);
    add(0, 0, 0, 1, 0, 32'h40, 0, 0, 1, 32'h40404040);
    add(0, 1, 32'h14, 0, 0, 0, 0, 1, 0, 32'h14141414);
    add(0, 0, 0, 1, 0, 32'h44, 0, 0, 1, 32'h44444444);
    add(0, 1, 32'h18, 0, 0, 0, 0, 1, 0, 32'h18181818);
    add(0, 0, 0, 1, 0, 32'h20, 0, 0, 1, 32'hDEADBEEF);
    idle(5);
    // Reset with two reads in flight, then a fresh fetch.
    add(0, 1, 32'h10, 0, 0, 0, 0, 1, 0, 32'hA5A5A5A5);
    add(0, 0, 0, 1, 0, 32'h40, 0, 0, 1, 32'h40404040);
    add(1, 1, 32'h14, 1, 0, 32'h44, 0, 0, 0, 0);
    idle(4);
    add(0, 1, 32'h14, 0, 0, 0, 0, 1, 0, 32'h14141414);
    idle(5);

    foreach (vecs[i]) apply(vecs[i]);

    @(negedge clk);
    chk("sb_drain", 0, 64'(sbq0.size()), 64'd0);
    chk("sb_drain", 1, 64'(sbq1.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
